// File: rtl/lock_input_if.sv
// Signal bundle between the raw lock panel inputs and the conditioned pulses.
// The glitch_cnt member exists only when LOCK_INPUT_GLITCH_CNT_EN is defined.
interface lock_input_if;
  logic       btn_set_raw;
  logic       btn_check_raw;
  logic [6:0] code_raw;
  logic       set_pulse;
  logic       check_pulse;
  logic [6:0] code_q;
  logic       set_held;
  logic       check_held;
`ifdef LOCK_INPUT_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  modport master (
    output btn_set_raw, btn_check_raw, code_raw,
    input  set_pulse, check_pulse, code_q, set_held, check_held
`ifdef LOCK_INPUT_GLITCH_CNT_EN
    , input glitch_cnt
`endif
  );

  modport slave (
    input  btn_set_raw, btn_check_raw, code_raw,
    output set_pulse, check_pulse, code_q, set_held, check_held
`ifdef LOCK_INPUT_GLITCH_CNT_EN
    , output glitch_cnt
`endif
  );
endinterface

// File: rtl/lock_input_conditioner.sv
// Synchronises, debounces and edge-detects the lock buttons and samples the code.
// Optional rejected-bounce counter enabled by defining LOCK_INPUT_GLITCH_CNT_EN.
module lock_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic         clk,
  input logic         rst_n,
  lock_input_if.slave io
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = set button, bit 1 = check button, bits 8:2 = code.
  logic [8:0]            s1, s2;
  logic [1:0]            held, held_nx;
  logic [1:0][CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]            abort, fall;
  logic                  set_pulse_r, check_pulse_r;
  logic [6:0]            code_r;

  // Stage 1: two-flop synchronisers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {io.code_raw, io.btn_check_raw, io.btn_set_raw};
      s2 <= s1;
    end
  end

  // Stage 2: debounce decision per button
  always_comb begin
    held_nx = held;
    cnt_nx  = cnt;
    abort   = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2[i] == held[i]) begin
        cnt_nx[i] = '0;
        abort[i]  = (cnt[i] != '0);
      end else if (cnt[i] == CNT_MAX) begin
        held_nx[i] = s2[i];
        cnt_nx[i]  = '0;
      end else begin
        cnt_nx[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  assign fall = held & ~held_nx;

  // Stage 3: stable levels, release pulses and code capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held          <= '0;
      cnt           <= '0;
      set_pulse_r   <= 1'b0;
      check_pulse_r <= 1'b0;
      code_r        <= '0;
    end else begin
      held          <= held_nx;
      cnt           <= cnt_nx;
      check_pulse_r <= fall[1];
      // A set release coinciding with a check release is dropped outright.
      set_pulse_r   <= fall[0] & ~fall[1];
      if (|fall) code_r <= s2[8:2];
    end
  end

  assign io.set_pulse   = set_pulse_r;
  assign io.check_pulse = check_pulse_r;
  assign io.code_q      = code_r;
  assign io.set_held    = held[0];
  assign io.check_held  = held[1];

`ifdef LOCK_INPUT_GLITCH_CNT_EN
  logic [7:0] glitch_r;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_r <= '0;
    else        glitch_r <= sat_add(glitch_r, {1'b0, abort[0]} + {1'b0, abort[1]});
  end

  assign io.glitch_cnt = glitch_r;
`else
  logic unused_abort;
  assign unused_abort = ^abort;
`endif

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed plus randomized bench for lock_input_conditioner with a cycle-level reference model.
// Glitch counter checks are active when LOCK_INPUT_GLITCH_CNT_EN is defined.
module tb_lock_input_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lock_input_if io();

  lock_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: raw samples delayed two edges, run-length of disagreement per button.
  logic [8:0] dq[$];
  bit   [1:0] m_held;
  int         m_run[2];
  bit         m_sp, m_cp;
  logic [6:0] m_code;
  int         m_glitch;
  int         n_set, n_check;

  task automatic model_clear();
    dq = '{9'd0, 9'd0};
    m_held = '0;
    m_run[0] = 0;
    m_run[1] = 0;
    m_sp = 0;
    m_cp = 0;
    m_code = '0;
    m_glitch = 0;
  endtask

  task automatic model_edge();
    logic [8:0] smp;
    bit   [1:0] fell;
    int         aborts;
    if (!rst_n) begin
      model_clear();
      return;
    end
    smp = dq.pop_front();
    dq.push_back({io.code_raw, io.btn_check_raw, io.btn_set_raw});
    fell = '0;
    aborts = 0;
    for (int b = 0; b < 2; b++) begin
      if (smp[b] == m_held[b]) begin
        if (m_run[b] > 0) aborts++;
        m_run[b] = 0;
      end else begin
        m_run[b]++;
        if (m_run[b] == D) begin
          if (m_held[b]) fell[b] = 1'b1;
          m_held[b] = smp[b];
          m_run[b] = 0;
        end
      end
    end
    m_cp = fell[1];
    m_sp = fell[0] && !fell[1];
    if (fell != 0) m_code = smp[8:2];
    m_glitch = (m_glitch + aborts > 255) ? 255 : m_glitch + aborts;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (io.set_pulse === 1'b1) n_set++;
    if (io.check_pulse === 1'b1) n_check++;
    chk("outputs", {io.set_pulse, io.check_pulse, io.set_held, io.check_held, io.code_q},
        {m_sp, m_cp, m_held[0], m_held[1], m_code});
`ifdef LOCK_INPUT_GLITCH_CNT_EN
    chk("glitch_cnt", io.glitch_cnt, m_glitch);
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ns0, nc0, g0;
    io.btn_set_raw = 1'b0;
    io.btn_check_raw = 1'b0;
    io.code_raw = 7'd0;
    n_set = 0;
    n_check = 0;
    model_clear();

    // Reset state
    #1;
    chk("rst_outputs", {io.set_pulse, io.check_pulse, io.set_held, io.check_held, io.code_q}, 0);
`ifdef LOCK_INPUT_GLITCH_CNT_EN
    chk("rst_glitch", io.glitch_cnt, 0);
`endif
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    // Clean check cycle
    io.code_raw = 7'h55;
    ticks(3);
    io.btn_check_raw = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (io.check_held !== 1'b1 && lat < 20);
    chk("check_rise_lat", lat, 6);
    for (int i = lat; i < 10; i++) tick();
    io.btn_check_raw = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (io.check_pulse !== 1'b1 && lat < 20);
    chk("check_pulse_lat", lat, 6);
    chk("check_code", io.code_q, 7'h55);
    chk("check_no_set", io.set_pulse, 0);
    tick();
    chk("pulse_width", io.check_pulse, 0);
    chk("check_count", n_check, 1);

    // Bounce rejection on the held set button
    io.btn_set_raw = 1'b1;
    ticks(10);
    ns0 = n_set;
`ifdef LOCK_INPUT_GLITCH_CNT_EN
    g0 = int'(io.glitch_cnt);
`else
    g0 = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      io.btn_set_raw = 1'b0;
      ticks(2);
      io.btn_set_raw = 1'b1;
      ticks(3);
    end
    ticks(10);
    chk("bounce_held", io.set_held, 1);
    chk("bounce_no_pulse", n_set - ns0, 0);
`ifdef LOCK_INPUT_GLITCH_CNT_EN
    chk("bounce_glitch", int'(io.glitch_cnt) - g0, 3);
`endif
    io.btn_set_raw = 1'b0;
    ticks(10);

    // Simultaneous release
    io.code_raw = 7'h12;
    ticks(3);
    io.btn_set_raw = 1'b1;
    io.btn_check_raw = 1'b1;
    ticks(10);
    ns0 = n_set;
    io.btn_set_raw = 1'b0;
    io.btn_check_raw = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (io.check_pulse !== 1'b1 && lat < 20);
    chk("simul_lat", lat, 6);
    chk("simul_set_pulse", io.set_pulse, 0);
    chk("simul_code", io.code_q, 7'h12);
    ticks(10);
    chk("simul_set_dropped", n_set - ns0, 0);

    // Code hold
    io.code_raw = 7'h7F;
    ticks(3);
    ns0 = n_set;
    io.btn_set_raw = 1'b1;
    ticks(10);
    io.btn_set_raw = 1'b0;
    ticks(10);
    chk("hold_set_count", n_set - ns0, 1);
    chk("hold_code_a", io.code_q, 7'h7F);
    io.code_raw = 7'h01;
    ticks(10);
    chk("hold_code_b", io.code_q, 7'h7F);

    // Reset mid-operation with check held
    nc0 = n_check;
    io.btn_check_raw = 1'b1;
    ticks(10);
    chk("pre_rst_held", io.check_held, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {io.set_pulse, io.check_pulse, io.set_held, io.check_held, io.code_q}, 0);
    tick();
    rst_n = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (io.check_held !== 1'b1 && lat < 20);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_no_pulse", n_check - nc0, 0);
    io.btn_check_raw = 1'b0;
    ticks(10);
    chk("post_rst_release", n_check - nc0, 1);

    // Glitch counter saturation
    io.btn_set_raw = 1'b1;
    ticks(8);
    for (int i = 0; i < 300; i++) begin
      io.btn_set_raw = 1'b0;
      ticks(2);
      io.btn_set_raw = 1'b1;
      ticks(2);
    end
`ifdef LOCK_INPUT_GLITCH_CNT_EN
    chk("glitch_sat", io.glitch_cnt, 255);
`endif
    chk("sat_no_pulse", io.set_held, 1);
    io.btn_set_raw = 1'b0;
    ticks(10);

    // Randomized activity against the model
    for (int i = 0; i < 400; i++) begin
      io.btn_set_raw = 1'($urandom_range(0, 1));
      io.btn_check_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) io.code_raw = 7'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_rst", {io.set_pulse, io.check_pulse, io.set_held, io.check_held, io.code_q}, 0);
        tick();
        rst_n = 1'b1;
      end
      ticks($urandom_range(1, 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
